// File: rtl/dem_usage_decoder_pkg.sv
// Shared DEM constants and the usage-decoder FSM state type.
// Everything derives from OUTPUT_WIDTH, MAX_LEVEL and QUANT_STEP so the DAC side and the monitor agree.
package dem_usage_decoder_pkg;

    localparam int OUTPUT_WIDTH = 3;
    localparam int MAX_LEVEL    = 7;
    localparam int INPUT_WIDTH  = 16;
    localparam int QUANT_STEP   = 1 << (INPUT_WIDTH - OUTPUT_WIDTH);

    localparam int NUM_ELEM            = MAX_LEVEL;
    localparam int LEVEL_W             = OUTPUT_WIDTH;
    localparam int DATA_W              = LEVEL_W + $clog2(QUANT_STEP);
    localparam int DEFAULT_WIN_LEN     = 64;
    localparam int DEFAULT_CNT_W       = 8;
    localparam int DEFAULT_MISMATCH_TH = 4;
    localparam int IDX_W               = $clog2(NUM_ELEM);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } usage_state_e;

endpackage

// File: rtl/dem_popcount.sv
// Combinational bit counter: number of enabled unit elements in a select vector.
module dem_popcount #(
    parameter int N = 7,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < N; i++) begin
            count_o = count_o + W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/dem_usage_decoder.sv
// Passive observer of the DEM select vector: rebuilds level/sample and reports
// per-window element usage spread (max-min) with a mismatch flag.
module dem_usage_decoder
    import dem_usage_decoder_pkg::*;
#(
    parameter int WIN_LEN     = DEFAULT_WIN_LEN,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int MISMATCH_TH = DEFAULT_MISMATCH_TH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel_valid,
    input  logic [NUM_ELEM-1:0] sel_vec,
    input  logic                usage_clr,
    output logic                level_valid,
    output logic [LEVEL_W-1:0]  level,
    output logic [DATA_W-1:0]   sample,
    output logic                win_done,
    output logic [CNT_W-1:0]    spread,
    output logic                mismatch
);

    logic [LEVEL_W-1:0] pop;
    logic               level_valid_q;
    logic [LEVEL_W-1:0] level_q;
    logic [DATA_W-1:0]  sample_q;

    logic [CNT_W-1:0]   cnt_q    [NUM_ELEM];
    logic [CNT_W-1:0]   cnt_d    [NUM_ELEM];
    logic [CNT_W-1:0]   shadow_q [NUM_ELEM];
    logic [CNT_W-1:0]   n_q;
    logic               win_end;

    usage_state_e       state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   max_q;
    logic [CNT_W-1:0]   min_q;
    logic [CNT_W-1:0]   spread_q;
    logic [CNT_W-1:0]   spread_d;
    logic               mismatch_q;
    logic               win_done_q;

    dem_popcount #(.N(NUM_ELEM), .W(LEVEL_W)) u_popcount (
        .vec_i   (sel_vec),
        .count_o (pop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_valid_q <= 1'b0;
            level_q       <= '0;
            sample_q      <= '0;
        end else begin
            level_valid_q <= sel_valid;
            if (sel_valid) begin
                level_q  <= pop;
                sample_q <= {pop, {(DATA_W-LEVEL_W){1'b0}}};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ELEM; i++) begin
            cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(sel_vec[i]);
        end
    end

    // Completing sample is folded into the shadow copy via cnt_d at the same edge.
    assign win_end = sel_valid && !usage_clr && (state_q == ACCUM) &&
                     (n_q == CNT_W'(WIN_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ELEM; i++) cnt_q[i] <= '0;
            n_q <= '0;
        end else if (usage_clr || win_end) begin
            for (int i = 0; i < NUM_ELEM; i++) cnt_q[i] <= '0;
            n_q <= '0;
        end else if (sel_valid) begin
            for (int i = 0; i < NUM_ELEM; i++) cnt_q[i] <= cnt_d[i];
            n_q <= n_q + 1'b1;
        end
    end

    assign spread_d = max_q - min_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACCUM;
            idx_q      <= '0;
            max_q      <= '0;
            min_q      <= '0;
            spread_q   <= '0;
            mismatch_q <= 1'b0;
            win_done_q <= 1'b0;
            for (int i = 0; i < NUM_ELEM; i++) shadow_q[i] <= '0;
        end else begin
            win_done_q <= 1'b0;
            if (usage_clr) begin
                state_q <= ACCUM;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (win_end) begin
                            for (int i = 0; i < NUM_ELEM; i++) shadow_q[i] <= cnt_d[i];
                            state_q <= SCAN;
                            idx_q   <= '0;
                            max_q   <= '0;
                            min_q   <= '1;
                        end
                    end
                    SCAN: begin
                        if (shadow_q[idx_q] > max_q) max_q <= shadow_q[idx_q];
                        if (shadow_q[idx_q] < min_q) min_q <= shadow_q[idx_q];
                        if (idx_q == IDX_W'(NUM_ELEM - 1)) state_q <= REPORT;
                        else                               idx_q   <= idx_q + 1'b1;
                    end
                    REPORT: begin
                        spread_q   <= spread_d;
                        mismatch_q <= (spread_d > CNT_W'(MISMATCH_TH));
                        win_done_q <= 1'b1;
                        state_q    <= ACCUM;
                    end
                    default: state_q <= ACCUM;
                endcase
            end
        end
    end

    assign level_valid = level_valid_q;
    assign level       = level_q;
    assign sample      = sample_q;
    assign win_done    = win_done_q;
    assign spread      = spread_q;
    assign mismatch    = mismatch_q;

endmodule

// File: tb/tb_dem_usage_decoder.sv
// Scoreboard bench for dem_usage_decoder: stimulus pushes expected decodes and
// window reports; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dem_usage_decoder;
    import dem_usage_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel_valid = 1'b0;
    logic [6:0] sel_vec = '0;
    logic       usage_clr = 1'b0;
    logic       level_valid;
    logic [2:0] level;
    logic [15:0] sample;
    logic       win_done;
    logic [7:0] spread;
    logic       mismatch;

    dem_usage_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .sel_valid   (sel_valid),
        .sel_vec     (sel_vec),
        .usage_clr   (usage_clr),
        .level_valid (level_valid),
        .level       (level),
        .sample      (sample),
        .win_done    (win_done),
        .spread      (spread),
        .mismatch    (mismatch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct { int lvl; int smp; } dec_t;
    typedef struct { int cyc; int spr; int mm; } rep_t;
    dec_t dq[$];
    rep_t rq[$];

    int m_cnt[7];
    int m_n = 0;
    int pend_edge = -1;
    int n_windows = 0;

    // Issue one clock of stimulus and advance the reference model for that edge.
    task automatic step(bit v, logic [6:0] vec, bit clr);
        int e, l, mx, mn;
        dec_t d;
        rep_t r;
        sel_valid = v;
        sel_vec   = vec;
        usage_clr = clr;
        e = cyc + 1;
        if (v) begin
            l = $countones(vec);
            d.lvl = l;
            d.smp = l * 8192;
            dq.push_back(d);
        end
        if (clr) begin
            if (pend_edge >= 0 && e <= pend_edge && rq.size() > 0) rq.delete(rq.size() - 1);
            pend_edge = -1;
            for (int i = 0; i < 7; i++) m_cnt[i] = 0;
            m_n = 0;
        end else if (v) begin
            for (int i = 0; i < 7; i++) m_cnt[i] += int'(vec[i]);
            m_n++;
            if (m_n == 64) begin
                mx = 0;
                mn = 255;
                for (int i = 0; i < 7; i++) begin
                    if (m_cnt[i] > mx) mx = m_cnt[i];
                    if (m_cnt[i] < mn) mn = m_cnt[i];
                end
                r.cyc = e + 8;
                r.spr = mx - mn;
                r.mm  = (mx - mn > 4) ? 1 : 0;
                rq.push_back(r);
                pend_edge = e + 8;
                n_windows++;
                for (int i = 0; i < 7; i++) m_cnt[i] = 0;
                m_n = 0;
            end
        end
        @(posedge clk);
        #1;
        sel_valid = 1'b0;
        usage_clr = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, 7'h00, 1'b0);
    endtask

    task automatic rotate64();
        for (int i = 0; i < 64; i++) step(1'b1, 7'(1 << (i % 7)), 1'b0);
    endtask

    int last_lvl = 0;
    int last_smp = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (level_valid) begin
                if (dq.size() == 0) begin
                    chk("unexpected level_valid", int'(level_valid), 0);
                end else begin
                    dec_t d;
                    d = dq.pop_front();
                    chk("level", int'(level), d.lvl);
                    chk("sample", int'(sample), d.smp);
                    last_lvl = d.lvl;
                    last_smp = d.smp;
                end
            end else begin
                chk("level hold", int'(level), last_lvl);
                chk("sample hold", int'(sample), last_smp);
            end
            if (win_done) begin
                if (rq.size() == 0) begin
                    chk("unexpected win_done", int'(win_done), 0);
                end else begin
                    rep_t r;
                    r = rq.pop_front();
                    chk("win_done cycle", cyc, r.cyc);
                    chk("spread", int'(spread), r.spr);
                    chk("mismatch", int'(mismatch), r.mm);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                chk("win_done missing", int'(win_done), 1);
                void'(rq.pop_front());
            end
        end
    end

    initial begin
        int w0, guard;
        repeat (3) @(posedge clk);
        chk("reset level_valid", int'(level_valid), 0);
        chk("reset level", int'(level), 0);
        chk("reset sample", int'(sample), 0);
        chk("reset win_done", int'(win_done), 0);
        chk("reset spread", int'(spread), 0);
        chk("reset mismatch", int'(mismatch), 0);
        #1 rst = 1'b0;

        // 1: idle, nothing should appear
        idle(200);

        // 2: single decodes
        step(1'b1, 7'b0000101, 1'b0);
        step(1'b1, 7'b1111111, 1'b0);
        idle(2);
        chk("level after 7'h7f", int'(level), 7);
        chk("sample after 7'h7f", int'(sample), 16'hE000);
        // these two samples belong to no window yet; flush them from the model
        step(1'b0, 7'h00, 1'b1);

        // 3: rotating one-hot window
        rotate64();
        idle(12);
        chk("rotating spread", int'(spread), 1);
        chk("rotating mismatch", int'(mismatch), 0);

        // 4: stuck element then rotating
        for (int i = 0; i < 64; i++) step(1'b1, 7'b0000001, 1'b0);
        idle(12);
        chk("stuck spread", int'(spread), 64);
        chk("stuck mismatch", int'(mismatch), 1);
        rotate64();
        idle(12);
        chk("recover spread", int'(spread), 1);
        chk("recover mismatch", int'(mismatch), 0);

        // 5: clear with a coincident valid sample
        for (int i = 0; i < 30; i++) step(1'b1, 7'b0000001, 1'b0);
        step(1'b1, 7'b1111111, 1'b1);
        rotate64();
        idle(12);
        chk("post-clear spread", int'(spread), 1);

        // 6: gapped random traffic, abort mid-scan, then a full window
        w0 = n_windows;
        guard = 0;
        while (n_windows == w0 && guard < 1000) begin
            step(1'($urandom_range(0, 1)), 7'($urandom), 1'b0);
            guard++;
        end
        chk("random window reached", int'(n_windows > w0), 1);
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 7'($urandom), 1'b0);
        step(1'b1, 7'($urandom), 1'b1);
        idle(12);
        w0 = n_windows;
        guard = 0;
        while (n_windows == w0 && guard < 1000) begin
            step(1'($urandom_range(0, 1)), 7'($urandom), 1'b0);
            guard++;
        end
        chk("second random window reached", int'(n_windows > w0), 1);
        idle(12);

        chk("decode queue drained", dq.size(), 0);
        chk("report queue drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dem_usage_decoder.md
Name: dem_usage_decoder

Overview:
Receive-side counterpart of the DEM switching block. It takes the per-cycle unit-element select vector driven to the DAC and reconstructs the quantized level and the equivalent INPUT_WIDTH sample. It also accumulates per-element usage over fixed windows and reports the usage spread, so the bench and the on-chip monitor can confirm that element matching is actually shaping mismatch. It sits beside the DAC element drivers as a passive observer.

Parameters:
NUM_ELEM, MAX_LEVEL (7), number of unit elements / select-vector width
LEVEL_W, OUTPUT_WIDTH (3), reconstructed level width
DATA_W, INPUT_WIDTH (16), reconstructed sample width
WIN_LEN, 64, valid samples per usage window; must be >= NUM_ELEM+2
CNT_W, 8, usage counter width; must be >= clog2(WIN_LEN+1)
MISMATCH_TH, 4, spread above which mismatch is flagged

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sel_valid  in  1  sel_vec is valid this cycle
sel_vec  in  NUM_ELEM  unit-element enables, any pattern legal (scrambled, not thermometer)
usage_clr  in  1  synchronous clear of the live window and abort of any scan
level_valid  out  1  level/sample valid
level  out  LEVEL_W  popcount of the captured sel_vec
sample  out  DATA_W  level << (DATA_W-LEVEL_W), i.e. level*QUANT_STEP
win_done  out  1  one-cycle pulse when a window report is published
spread  out  CNT_W  max-min element usage of the last completed window
mismatch  out  1  spread > MISMATCH_TH for the last completed window

Behaviour:
- Reset (async, rst=1): every output 0; all counters, the sample count and shadow registers 0; FSM in ACCUM.
- Decode path: on a clk edge with sel_valid=1, register level=popcount(sel_vec) and sample=level<<(DATA_W-LEVEL_W).
  - Latency is 1 cycle. level_valid equals sel_valid delayed by one cycle.
  - With sel_valid=0, level_valid=0 and level/sample hold their last values.
  - Example: level 7 gives sample 0xE000.
  - Decoding is independent of the FSM state and of usage_clr.
- Usage path: each valid sample adds sel_vec[i] to live counter i and increments the sample count.
  - Counters saturate at all-ones; this cannot be reached when the parameter constraints hold.
- FSM states: ACCUM, SCAN, REPORT.
  - ACCUM: on the valid sample that brings the count to WIN_LEN, counters (including that sample) are copied to the shadow array at that edge. Live counters and the count clear at the same edge, and the FSM goes to SCAN with idx=0, max=0, min=all-ones.
  - SCAN: one element per cycle. Update max/min from shadow[idx]. After NUM_ELEM cycles go to REPORT.
  - REPORT: single cycle. Register spread=max-min and mismatch=(spread>MISMATCH_TH), assert win_done, return to ACCUM.
  - Timing: win_done is high for exactly one cycle, NUM_ELEM+1 edges after the edge that sampled the final window sample.
  - spread and mismatch hold until the next REPORT.
- Live accumulation continues during SCAN and REPORT. The next window is counted normally; the WIN_LEN >= NUM_ELEM+2 constraint means no window can complete mid-scan.
- usage_clr=1 at an edge:
  - Clears live counters and the sample count.
  - Aborts SCAN/REPORT back to ACCUM; no win_done is produced for the aborted window.
  - spread and mismatch keep their previous values.
  - If sel_valid is also 1, clear wins: that sample is decoded but not counted.
- sel_valid gaps do not advance the window or the counters.

Decomposition:
- Add to the shared DEM package: LFSR-independent constants NUM_ELEM, LEVEL_W, DEFAULT_WIN_LEN and DEFAULT_MISMATCH_TH. They derive from OUTPUT_WIDTH, MAX_LEVEL and QUANT_STEP, which remain the single source.
- Add a typedef enum for the FSM state {ACCUM, SCAN, REPORT} to the same package.
- One natural sub-module: dem_popcount, a combinational NUM_ELEM -> LEVEL_W bit counter, reused by the switching-block checker.

Test Plan:
1. Hold rst=1, then release; drive no valids -> all outputs 0, no win_done for 200 cycles.
2. sel_valid=1, sel_vec=7'b0000101 for one cycle -> next cycle level_valid=1, level=2, sample=0x4000. sel_vec=7'b1111111 -> level=7, sample=0xE000.
3. 64 valid one-hot vectors rotating element 0..6 -> usage 10,9,9,9,9,9,9. win_done pulses 8 edges after the 64th sample with spread=1, mismatch=0.
4. 64 valid vectors of 7'b0000001 -> spread=64, mismatch=1. A following rotating window -> spread=1, mismatch=0.
5. 30 stuck samples, then usage_clr together with a valid sample, then 64 rotating samples -> the clear-cycle sample is decoded but not counted. A single win_done follows the 64th post-clear sample with spread=1.
6. Randomly gapped sel_valid (about 50%), plus usage_clr asserted during SCAN -> no win_done for the aborted window. Windows are counted only on valid samples, and decoded levels match popcount every valid cycle.
